// File: rtl/addr_req_ack_pkg.sv
// Shared types and helpers for the multi-channel address-matched REQ/ACK acceptor.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package addr_req_ack_pkg;

  // Handshake FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Width of a channel index. A single channel still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addr_req_ack_arb_rr_arbiter.sv
// Round-robin pick: first eligible channel scanning upward from rr_ptr+1 with wrap.
// Latency: purely combinational.
// Backpressure: none; any_valid is low when nothing is eligible.
module rr_arbiter
  import addr_req_ack_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int ID_W = id_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [ID_W-1:0]   rr_ptr,
  output logic [ID_W-1:0]   grant_id,
  output logic              any_valid
);

  localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

  // Walk offsets 1..NUM_CH from the pointer; the last-granted channel is checked last.
  always_comb begin
    int idx;
    idx       = 0;
    grant_id  = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!any_valid && ((eligible & (ONE << idx)) != '0)) begin
        any_valid = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/addr_req_ack_arb.sv
// Multi-channel address-matched REQ/ACK acceptor with round-robin grant, hold timeout and miss report.
// Latency: ACK_OUT rises ACK_LAT edges after the accepting edge; release one edge after REQ drops.
// Backpressure: one grant at a time; other matching requesters wait; a timed-out channel is blocked until it drops REQ.
module addr_req_ack_arb
  import addr_req_ack_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 2,
  parameter int ACK_LAT = 2,
  parameter int TIMEOUT = 15,
  localparam int ID_W = id_width(NUM_CH)
) (
  input  logic                     CLK_IN,
  input  logic                     RST_N_IN,
  input  logic [ADDR_W-1:0]        MY_ADDR_IN,
  input  logic [NUM_CH-1:0]        REQ_IN,
  input  logic [NUM_CH*ADDR_W-1:0] ADDR_IN,
  input  logic                     ERR_CLR_IN,
  output logic [NUM_CH-1:0]        ACK_OUT,
  output logic                     GRANT_VALID_OUT,
  output logic [ID_W-1:0]          GRANT_ID_OUT,
  output logic [NUM_CH-1:0]        MISS_OUT,
  output logic                     ERR_OUT
);

  localparam int CNT_W  = $clog2(ACK_LAT + 1);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

  state_t              state;
  logic [ID_W-1:0]     grant_q;
  logic [ID_W-1:0]     rr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [TCNT_W-1:0]   tcnt_q;
  logic [NUM_CH-1:0]   block_q;
  logic [NUM_CH-1:0]   ack_q;
  logic                gvld_q;
  logic [NUM_CH-1:0]   miss_q;
  logic                err_q;

  logic [NUM_CH-1:0]   addr_match;
  logic [NUM_CH-1:0]   eligible;
  logic [ID_W-1:0]     arb_id;
  logic                arb_vld;
  logic [NUM_CH-1:0]   grant_oh;
  logic                req_g;
  logic                timeout;

  // Per-channel address compare; blocked channels are masked out of arbitration.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_match
    assign addr_match[i] = (ADDR_IN[i*ADDR_W +: ADDR_W] == MY_ADDR_IN);
    assign eligible[i]   = REQ_IN[i] & addr_match[i] & ~block_q[i];
  end

  assign grant_oh = ONE << grant_q;
  assign req_g    = |(REQ_IN & grant_oh);
  assign timeout  = (state == ACK) && req_g && (tcnt_q == TCNT_W'(TIMEOUT - 1));

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .eligible  (eligible),
    .rr_ptr    (rr_q),
    .grant_id  (arb_id),
    .any_valid (arb_vld)
  );

  // Handshake FSM: accept, count down latency, hold ACK until REQ drops or the hold times out.
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      state   <= IDLE;
      grant_q <= '0;
      rr_q    <= ID_W'(NUM_CH - 1);
      cnt_q   <= '0;
      tcnt_q  <= '0;
      ack_q   <= '0;
      gvld_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_vld) begin
            grant_q <= arb_id;
            rr_q    <= arb_id;
            gvld_q  <= 1'b1;
            cnt_q   <= CNT_W'(ACK_LAT - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (!req_g) begin
            gvld_q <= 1'b0;
            state  <= IDLE;
          end else if (cnt_q == '0) begin
            ack_q  <= grant_oh;
            tcnt_q <= '0;
            state  <= ACK;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ACK: begin
          if (!req_g || timeout) begin
            ack_q  <= '0;
            gvld_q <= 1'b0;
            state  <= IDLE;
          end else begin
            tcnt_q <= tcnt_q + TCNT_W'(1);
          end
        end
        default: begin
          ack_q  <= '0;
          gvld_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Block mask: set on timeout, cleared by the channel dropping REQ; sticky error with timeout winning over clear.
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      block_q <= '0;
      err_q   <= 1'b0;
    end else begin
      block_q <= (block_q & REQ_IN) | (timeout ? grant_oh : '0);
      err_q   <= timeout | (err_q & ~ERR_CLR_IN);
    end
  end

  // Miss report: requests for some other address, registered every cycle.
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      miss_q <= '0;
    end else begin
      miss_q <= REQ_IN & ~addr_match;
    end
  end

  assign ACK_OUT         = ack_q;
  assign GRANT_VALID_OUT = gvld_q;
  assign GRANT_ID_OUT    = grant_q;
  assign MISS_OUT        = miss_q;
  assign ERR_OUT         = err_q;

endmodule

// File: tb/tb_addr_req_ack_arb.sv
// Scoreboard bench: stimulus queues expected output states with their cycle; monitor pops on every output change.
// Latency: checks exact cycle of each change.
// Backpressure: n/a.
module tb_addr_req_ack_arb;

  localparam int NUM_CH  = 4;
  localparam int ADDR_W  = 2;
  localparam int ACK_LAT = 2;
  localparam int TIMEOUT = 3;

  logic       clk;
  logic       rst_n;
  logic [1:0] my_addr;
  logic [3:0] req;
  logic [7:0] addr;
  logic       err_clr;
  logic [3:0] ack;
  logic       gvld;
  logic [1:0] gid;
  logic [3:0] miss;
  logic       err;

  addr_req_ack_arb #(
    .NUM_CH  (NUM_CH),
    .ADDR_W  (ADDR_W),
    .ACK_LAT (ACK_LAT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK_IN          (clk),
    .RST_N_IN        (rst_n),
    .MY_ADDR_IN      (my_addr),
    .REQ_IN          (req),
    .ADDR_IN         (addr),
    .ERR_CLR_IN      (err_clr),
    .ACK_OUT         (ack),
    .GRANT_VALID_OUT (gvld),
    .GRANT_ID_OUT    (gid),
    .MISS_OUT        (miss),
    .ERR_OUT         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0] ack;
    logic       gv;
    logic [1:0] gid;
    logic [3:0] miss;
    logic       err;
  } obs_t;

  obs_t  exp_q[$];
  int    cyc_q[$];
  string name_q[$];
  int    checks = 0;
  int    fails  = 0;
  bit    done   = 1'b0;

  task automatic expect_at(input int c, input string nm, input logic [3:0] a, input logic v,
                           input logic [1:0] id, input logic [3:0] m, input logic e);
    obs_t o;
    o.ack  = a;
    o.gv   = v;
    o.gid  = v ? id : 2'd0;
    o.miss = m;
    o.err  = e;
    exp_q.push_back(o);
    cyc_q.push_back(c);
    name_q.push_back(nm);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every change of the observable output state must match the next queued expectation.
  initial begin
    obs_t  cur;
    obs_t  prev;
    obs_t  e;
    int    ec;
    string en;
    bit    first;
    first = 1'b1;
    prev  = '0;
    forever begin
      @(negedge clk);
      cur.ack  = ack;
      cur.gv   = gvld;
      cur.gid  = gvld ? gid : 2'd0;
      cur.miss = miss;
      cur.err  = err;
      if (first || (cur !== prev)) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change cyc=%0d got ack=%b gv=%b id=%0d miss=%b err=%b required no change",
                   cyc, cur.ack, cur.gv, cur.gid, cur.miss, cur.err);
        end else begin
          e  = exp_q.pop_front();
          ec = cyc_q.pop_front();
          en = name_q.pop_front();
          if ((cur !== e) || (cyc != ec)) begin
            fails++;
            $display("FAIL %s got cyc=%0d ack=%b gv=%b id=%0d miss=%b err=%b required cyc=%0d ack=%b gv=%b id=%0d miss=%b err=%b",
                     en, cyc, cur.ack, cur.gv, cur.gid, cur.miss, cur.err,
                     ec, e.ack, e.gv, e.gid, e.miss, e.err);
          end
        end
      end
      prev  = cur;
      first = 1'b0;
      if (done || cyc > 1000) begin
        checks++;
        if (cyc > 1000) begin
          fails++;
          $display("FAIL watchdog got cyc=%0d required stimulus done before 1000", cyc);
        end else if (exp_q.size() != 0) begin
          fails++;
          $display("FAIL pending_expectations got %0d left required 0 (next %s at cyc %0d)",
                   exp_q.size(), name_q[0], cyc_q[0]);
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
      end
    end
  end

  // Stimulus: directed scenarios, each pushing its hand-computed output changes.
  initial begin
    int n;
    int g;
    int order[6];
    logic [3:0] oh;
    order   = '{3, 0, 1, 3, 0, 1};
    rst_n   = 1'b0;
    req     = 4'b0000;
    addr    = 8'hAA;          // every channel addresses 2
    my_addr = 2'd2;
    err_clr = 1'b0;
    expect_at(1, "reset_state", 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request on channel 1: grant next edge, ACK two edges later, release one edge after REQ drops.
    n = cyc;
    req[1] = 1'b1;
    expect_at(n + 1, "t1_grant",   4'b0000, 1'b1, 2'd1, 4'b0000, 1'b0);
    expect_at(n + 3, "t1_ack",     4'b0010, 1'b1, 2'd1, 4'b0000, 1'b0);
    wait_to(n + 3);
    req[1] = 1'b0;
    expect_at(n + 4, "t1_release", 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);
    wait_to(n + 4);

    // Round robin over channels 0,1,3 with pointer left at 1: order 3,0,1,3,0,1.
    n   = cyc;
    req = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      g  = order[i];
      oh = 4'b0001 << g;
      expect_at(n + 1, "t2_grant",   4'b0000, 1'b1, 2'(g), 4'b0000, 1'b0);
      expect_at(n + 3, "t2_ack",     oh,      1'b1, 2'(g), 4'b0000, 1'b0);
      expect_at(n + 4, "t2_release", 4'b0000, 1'b0, 2'd0,  4'b0000, 1'b0);
      wait_to(n + 3);
      req[g] = 1'b0;
      wait_to(n + 4);
      if (i < 5) req[g] = 1'b1;
      else       req = 4'b0000;
      n = n + 4;
    end

    // Address miss on channel 2: reported one edge later, no grant.
    n = cyc;
    addr[5:4] = 2'd1;
    req[2]    = 1'b1;
    expect_at(n + 1, "t3_miss",       4'b0000, 1'b0, 2'd0, 4'b0100, 1'b0);
    wait_to(n + 2);
    req[2] = 1'b0;
    expect_at(n + 3, "t3_miss_clear", 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);
    wait_to(n + 3);
    addr[5:4] = 2'd2;

    // Hold timeout on channel 0: ACK for 3 cycles, error, blocked while REQ held, clear, re-grant after drop.
    n = cyc;
    req[0] = 1'b1;
    expect_at(n + 1, "t4_grant",   4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0);
    expect_at(n + 3, "t4_ack",     4'b0001, 1'b1, 2'd0, 4'b0000, 1'b0);
    expect_at(n + 6, "t4_timeout", 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1);
    wait_to(n + 8);
    err_clr = 1'b1;
    expect_at(n + 9, "t4_err_clr", 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);
    wait_to(n + 9);
    err_clr = 1'b0;
    req[0]  = 1'b0;
    wait_to(n + 10);
    req[0] = 1'b1;
    expect_at(n + 11, "t4_regrant", 4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0);
    expect_at(n + 13, "t4_reack",   4'b0001, 1'b1, 2'd0, 4'b0000, 1'b0);
    wait_to(n + 13);
    req[0] = 1'b0;
    expect_at(n + 14, "t4_release", 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);
    wait_to(n + 14);

    // Abort in WAIT: channel 3 drops REQ before ACK; pending channel 0 granted on the next edge.
    n   = cyc;
    req = 4'b1001;
    expect_at(n + 1, "t5_grant3", 4'b0000, 1'b1, 2'd3, 4'b0000, 1'b0);
    wait_to(n + 1);
    req[3] = 1'b0;
    expect_at(n + 2, "t5_abort",  4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);
    expect_at(n + 3, "t5_grant0", 4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0);
    expect_at(n + 5, "t5_ack0",   4'b0001, 1'b1, 2'd0, 4'b0000, 1'b0);
    wait_to(n + 5);

    // Asynchronous reset while ACK is high: outputs clear before the next edge; re-grant after release.
    expect_at(n + 6, "t6_async_reset", 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expect_at(n + 8,  "t6_regrant", 4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0);
    expect_at(n + 10, "t6_reack",   4'b0001, 1'b1, 2'd0, 4'b0000, 1'b0);
    wait_to(n + 10);
    req = 4'b0000;
    expect_at(n + 11, "t6_release", 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);
    wait_to(n + 14);
    done = 1'b1;
  end

endmodule
